// File: rtl/fifo_pong_n.sv
// fifo_pong_n: DEPTH-entry circular register FIFO with ENA/RDY enq/deq methods
// Ports:
//   CLK, nRST                  clock, async active-low reset
//   in_enq__ENA/_v/__RDY       enqueue request, data, ready
//   out_deq__ENA/__RDY         dequeue request, ready
//   out_first/__RDY            head-of-queue data and its valid
//   flush                      synchronous clear (wins over enq/deq)
//   count                      occupancy 0..DEPTH
//   err                        sticky protocol-violation flag
module fifo_pong_n #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_enq__ENA,
    input  logic [WIDTH-1:0] in_enq_v,
    output logic             in_enq__RDY,
    input  logic             out_deq__ENA,
    output logic             out_deq__RDY,
    output logic [WIDTH-1:0] out_first,
    output logic             out_first__RDY,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic             err
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic             enq_fire, deq_fire, bad;
    assign in_enq__RDY    = count != CW'(DEPTH);
    assign out_deq__RDY   = count != '0;
    assign out_first__RDY = out_deq__RDY;
    assign out_first      = mem[rd_ptr[AW-1:0]];
    assign enq_fire       = in_enq__ENA && in_enq__RDY;
    assign deq_fire       = out_deq__ENA && out_deq__RDY;
    assign wr_nxt         = (wr_ptr == CW'(DEPTH - 1)) ? '0 : wr_ptr + CW'(1);
    assign rd_nxt         = (rd_ptr == CW'(DEPTH - 1)) ? '0 : rd_ptr + CW'(1);
    // A refused request is excused when the opposite side fires in the same
    // cycle (enq on full with a deq, deq on empty with an enq).
    assign bad = (in_enq__ENA && !in_enq__RDY && !deq_fire) ||
                 (out_deq__ENA && !out_deq__RDY && !enq_fire);
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (enq_fire && !flush) begin
            mem[wr_ptr[AW-1:0]] <= in_enq_v;
        end
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (enq_fire) wr_ptr <= wr_nxt;
            if (deq_fire) rd_ptr <= rd_nxt;
            if (enq_fire && !deq_fire) count <= count + CW'(1);
            if (deq_fire && !enq_fire) count <= count - CW'(1);
            if (bad) err <= 1'b1;
        end
    end
endmodule
